// File: rtl/riscvsc_uart_mmio_if.sv
// Data-memory port bundle between the single-cycle core and the MMIO UART.
// The core owns the request side; the UART answers with ReadData/Sel.
interface riscvsc_uart_mmio_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Sel;

    modport master (output MemWrite, ALUResult, WriteData, input ReadData, Sel);
    modport slave  (input MemWrite, ALUResult, WriteData, output ReadData, Sel);
endinterface

// File: rtl/riscvsc_uart_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS window, small TX FIFO,
// baud-rate serializer FSM with a registered serial output.
module riscvsc_uart_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    riscvsc_uart_mmio_if.slave bus,
    output logic               tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bitidx_q, bitidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic       sel, wr, wr_txdata, wr_status;
    logic       empty, full, busy, push, pop;
    logic [1:0] regsel;
    logic       unused_bits;

    // Decode
    assign sel       = bus.ALUResult[31:4] == BASE_ADDR[31:4];
    assign regsel    = bus.ALUResult[3:2];
    assign wr        = bus.MemWrite && sel;
    assign wr_txdata = wr && (regsel == 2'd0);
    assign wr_status = wr && (regsel == 2'd1);

    assign empty = count_q == '0;
    assign full  = count_q == DEPTH_C;
    assign busy  = state_q != IDLE;
    // full is the pre-edge value, so a store while full is dropped even if
    // the serializer pops on the same edge.
    assign push  = wr_txdata && !full;
    assign pop   = (state_q == IDLE) && !empty;

    assign bus.Sel      = sel;
    assign bus.ReadData = (sel && regsel == 2'd1) ?
                          {28'b0, overflow_q, busy, full, empty} : 32'b0;

    assign unused_bits = ^{bus.WriteData[31:8], bus.ALUResult[1:0]};

    // FIFO storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= bus.WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // Setting takes priority over a clear on the same edge.
            if (wr_txdata && full)
                overflow_q <= 1'b1;
            else if (wr_status && bus.WriteData[3])
                overflow_q <= 1'b0;
        end
    end

    // TX FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bitidx_q <= '0;
            shreg_q  <= '0;
            tx       <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            tx       <= tx_d;
        end
    end

    // TX FSM: next state
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    baud_d  = BAUD_MAX;
                    shreg_d = mem[rptr_q];
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d  = DATA;
                    baud_d   = BAUD_MAX;
                    bitidx_d = '0;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bitidx_q == 3'd7) state_d = STOP;
                    else                  bitidx_d = bitidx_q + 3'd1;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) state_d = IDLE;
                else              baud_d  = baud_q - BW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // TX FSM: output, looked up from the next state so tx can be a flop
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_riscvsc_uart_mmio.sv
// Bench for riscvsc_uart_mmio: queue-level UART model checked every cycle,
// a line decoder, and directed stores with hand-computed expectations.
module tb_riscvsc_uart_mmio;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STATUS = 32'h1000_0004;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx;

    riscvsc_uart_mmio_if bus();

    riscvsc_uart_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx)
    );

    initial forever #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte queue for the FIFO, a per-cycle queue of line levels for
    // the frame being sent, and a flag telling whether a frame bit is on the line.
    logic [7:0] mq[$];
    bit         mline[$];
    bit         mtx  = 1'b1;
    bit         mact = 1'b0;
    bit         movf = 1'b0;

    function automatic logic [3:0] mstatus();
        return {movf, mact, mq.size() == DEPTH, mq.size() == 0};
    endfunction

    initial begin : model
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                mline.delete();
                mtx  = 1'b1;
                mact = 1'b0;
                movf = 1'b0;
            end else begin
                bit hit, wtx, wst, was_full;
                logic [7:0] b;
                hit = bus.MemWrite && (bus.ALUResult[31:4] == BASE[31:4]);
                wtx = hit && bus.ALUResult[3:2] == 2'd0;
                wst = hit && bus.ALUResult[3:2] == 2'd1;
                was_full = mq.size() == DEPTH;
                if (!mact && mq.size() > 0) begin
                    b = mq.pop_front();
                    for (int k = 0; k < CPB; k++) mline.push_back(1'b0);
                    for (int i = 0; i < 8; i++)
                        for (int k = 0; k < CPB; k++) mline.push_back(b[i]);
                    for (int k = 0; k < CPB; k++) mline.push_back(1'b1);
                end
                if (wtx && !was_full) mq.push_back(bus.WriteData[7:0]);
                if (wtx && was_full) movf = 1'b1;
                else if (wst && bus.WriteData[3]) movf = 1'b0;
                if (mline.size() > 0) begin
                    mtx  = mline.pop_front();
                    mact = 1'b1;
                end else begin
                    mtx  = 1'b1;
                    mact = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic        esel;
        logic [31:0] erd;
        esel = bus.ALUResult[31:4] == BASE[31:4];
        erd  = (esel && bus.ALUResult[3:2] == 2'd1) ? {28'b0, mstatus()} : 32'b0;
        check("model_tx", {31'b0, tx}, {31'b0, mtx});
        check("model_sel", {31'b0, bus.Sel}, {31'b0, esel});
        check("model_rdata", bus.ReadData, erd);
    end

    // Line decoder: samples each bit in its middle cycle
    logic [7:0] rxq[$];
    initial begin : rx_dec
        int ph;
        bit act;
        logic [7:0] sh;
        act = 1'b0;
        ph  = 0;
        sh  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1;
                    ph  = 0;
                end
            end else begin
                ph++;
                for (int i = 0; i < 8; i++)
                    if (ph == CPB * (i + 1) + CPB / 2) sh[i] = tx;
                if (ph == CPB * 9 + CPB / 2) rxq.push_back(sh);
                if (ph == CPB * 10 - 1) act = 1'b0;
            end
        end
    end

    task automatic set_bus(input bit we, input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = we;
        bus.ALUResult = a;
        bus.WriteData = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        set_bus(1'b0, STATUS, 32'h0);
        while (n < maxc) begin
            @(negedge clk);
            if (bus.ReadData[2:0] == 3'b001) break;
            n++;
        end
        check("drain_in_time", {31'b0, n < maxc}, 32'h1);
        step();
    endtask

    int a5_exp[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic       txs[42];
    logic [3:0] sts[42];
    int         nbusy;

    initial begin
        set_bus(1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_tx", {31'b0, tx}, 32'h1);
        check("reset_sel_addr0", {31'b0, bus.Sel}, 32'h0);
        check("reset_rdata_addr0", bus.ReadData, 32'h0);
        set_bus(1'b0, STATUS, 32'h0);
        #1 check("reset_status", bus.ReadData, 32'h1);
        step();

        // Single 0xA5 frame
        set_bus(1'b1, BASE, 32'hA5);
        step();
        set_bus(1'b0, STATUS, 32'h0);
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            txs[k] = tx;
            sts[k] = bus.ReadData[3:0];
        end
        check("a5_before_start", {31'b0, txs[0]}, 32'h1);
        nbusy = 0;
        for (int k = 1; k <= 40; k++) begin
            check("a5_bit", {31'b0, txs[k]}, a5_exp[(k - 1) / CPB]);
            if (sts[k][2]) nbusy++;
        end
        check("a5_busy_cycles", nbusy, 32'd40);
        check("a5_idle_tx", {31'b0, txs[41]}, 32'h1);
        check("a5_idle_status", {28'b0, sts[41]}, 32'h1);
        step();
        check("a5_decoded", {24'b0, rxq[0]}, 32'hA5);

        // Six back-to-back stores: one popped, four queued, one dropped
        for (int i = 1; i <= 6; i++) begin
            set_bus(1'b1, BASE, i);
            step();
        end
        set_bus(1'b0, STATUS, 32'h0);
        #1 check("six_status_full_ovf", bus.ReadData, 32'hE);
        step();
        set_bus(1'b1, STATUS, 32'h8);
        step();
        set_bus(1'b0, STATUS, 32'h0);
        #1 check("ovf_cleared", bus.ReadData, 32'h6);
        step();
        set_bus(1'b1, BASE, 32'h77);
        step();
        set_bus(1'b0, STATUS, 32'h0);
        #1 check("ovf_set_again", bus.ReadData, 32'hE);
        wait_idle(400);
        check("drain_status", bus.ReadData, 32'h9);
        check("rx_count", rxq.size(), 32'd6);
        for (int i = 1; i <= 5; i++)
            check("rx_byte", {24'b0, rxq[i]}, i);
        set_bus(1'b1, STATUS, 32'h8);
        step();
        set_bus(1'b0, STATUS, 32'h0);
        #1 check("ovf_clear_idle", bus.ReadData, 32'h1);
        step();

        // Reset in the middle of the 0x55 frame, with 0x33 still queued
        set_bus(1'b1, BASE, 32'h55);
        step();
        set_bus(1'b1, BASE, 32'h33);
        step();
        set_bus(1'b0, STATUS, 32'h0);
        repeat (9) step();
        check("mid55_tx_bit1", {31'b0, tx}, 32'h0);
        check("mid55_status", bus.ReadData, 32'h4);
        #1 reset = 1'b1;
        #1;
        check("async_reset_tx", {31'b0, tx}, 32'h1);
        check("async_reset_status", bus.ReadData, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("post_reset_status", bus.ReadData, 32'h1);
        repeat (100) step();
        check("post_reset_no_frames", rxq.size(), 32'd6);
        check("post_reset_tx_idle", {31'b0, tx}, 32'h1);

        // Outside the window, and an unused register inside it
        set_bus(1'b1, BASE + 32'h10, 32'h99);
        #1;
        check("out_of_window_sel", {31'b0, bus.Sel}, 32'h0);
        check("out_of_window_rdata", bus.ReadData, 32'h0);
        step();
        set_bus(1'b1, BASE + 32'h8, 32'h99);
        #1;
        check("reserved_sel", {31'b0, bus.Sel}, 32'h1);
        check("reserved_rdata", bus.ReadData, 32'h0);
        step();
        set_bus(1'b0, STATUS, 32'h0);
        #1 check("no_push_status", bus.ReadData, 32'h1);
        repeat (50) step();
        check("no_push_frames", rxq.size(), 32'd6);
        check("no_push_tx", {31'b0, tx}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
